// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for the EX stage (RV32M DIV/DIVU/REM/REMU).
// One quotient bit is resolved per cycle. Divide-by-zero and signed overflow
// are resolved when the request is accepted, so they finish one cycle later.
module ex_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            cancel_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic            stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;       // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   dvs_q, dvs_d;       // divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              sel_rem_q, sel_rem_d; // op selects remainder (REM/REMU)
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic              accept_s;
  logic              is_signed_s;
  logic              div_zero_s;
  logic              ovf_s;
  logic [XLEN-1:0]   op1_abs_s;
  logic [XLEN-1:0]   op2_abs_s;
  logic [XLEN-1:0]   special_s;
  logic [XLEN:0]     shifted_s;
  logic [XLEN:0]     trial_s;
  logic [XLEN-1:0]   rem_step_s;
  logic [XLEN-1:0]   quo_step_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  // Operand conditioning, special-case detection and one restoring-division step.
  always_comb begin
    accept_s    = (state_q == S_IDLE) && start_i && !cancel_i;
    is_signed_s = !op_i[0];
    op1_abs_s   = (is_signed_s && op1_i[XLEN-1]) ? (~op1_i + ONE) : op1_i;
    op2_abs_s   = (is_signed_s && op2_i[XLEN-1]) ? (~op2_i + ONE) : op2_i;
    div_zero_s  = (op2_i == ZERO);
    ovf_s       = is_signed_s && (op1_i == MIN_NEG) && (op2_i == ALL_ONES);
    if (op_i[1]) begin
      special_s = div_zero_s ? op1_i : ZERO;
    end else begin
      special_s = div_zero_s ? ALL_ONES : MIN_NEG;
    end

    shifted_s = {rem_q, quo_q[XLEN-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
    if (!trial_s[XLEN]) begin
      rem_step_s = trial_s[XLEN-1:0];
      quo_step_s = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step_s = shifted_s[XLEN-1:0];
      quo_step_s = {quo_q[XLEN-2:0], 1'b0};
    end
    quo_fix_s = neg_quo_q ? (~quo_step_s + ONE) : quo_step_s;
    rem_fix_s = neg_rem_q ? (~rem_step_s + ONE) : rem_step_s;
  end

  // Next-state and datapath-register update selection for the IDLE/BUSY/DONE FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    waddr_d   = waddr_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          sel_rem_d = op_i[1];
          waddr_d   = reg_waddr_i;
          cnt_d     = CNT_ZERO;
          rem_d     = ZERO;
          quo_d     = op1_abs_s;
          dvs_d     = op2_abs_s;
          neg_quo_d = is_signed_s && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
          neg_rem_d = is_signed_s && op1_i[XLEN-1];
          if (div_zero_s || ovf_s) begin
            result_d = special_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cancel_i) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = CNT_ZERO;
            result_d = sel_rem_q ? rem_fix_s : quo_fix_s;
            state_d  = S_DONE;
          end else begin
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = S_BUSY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      rem_q     <= ZERO;
      quo_q     <= ZERO;
      dvs_q     <= ZERO;
      result_q  <= ZERO;
      waddr_q   <= 5'd0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      waddr_q   <= waddr_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Output drive: the strobe and stall must react to cancel/start in the same cycle.
  always_comb begin
    result_o    = result_q;
    reg_waddr_o = waddr_q;
    valid_o     = (state_q == S_DONE) && !cancel_i;
    reg_we_o    = valid_o;
    stall_req_o = accept_s || (state_q == S_BUSY);
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div.
module tb_ex_div;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] op1_i = 32'd0;
  logic [31:0] op2_i = 32'd0;
  logic [4:0]  reg_waddr_i = 5'd0;
  logic        cancel_i = 1'b0;
  logic [31:0] result_o;
  logic        valid_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        stall_req_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_div #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .cancel_i    (cancel_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and check latency, stall length, strobe, result and address.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stall_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; reg_waddr_i = wa;
    #1;
    stall_cnt = stall_req_o ? 1 : 0;
    @(posedge clk_i); #1;
    start_i = 1'b0; op1_i = 32'hDEAD_BEEF; op2_i = 32'h0000_0000; reg_waddr_i = 5'd31;
    lat = 1;
    while (!valid_o && lat < 60) begin
      if (stall_req_o) stall_cnt++;
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
    chk({tag, "_we"}, {31'd0, reg_we_o}, 32'd1);
    chk({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    chk({tag, "_pulse_end"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int vcnt;
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_result", result_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_we", {31'd0, reg_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    // Normal path
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 33);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd11, 32'd2, 33);
    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 33);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'hFFFF_FFFF, 33);
    run_op("div_min_1",  OP_DIV,  32'h8000_0000, 32'd1, 5'd6, 32'h8000_0000, 33);
    run_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd7, 32'h0000_000F, 33);

    // Special cases
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",  OP_REM,  32'h1234, 32'd0, 5'd13, 32'h0000_1234, 1);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1);
    run_op("divu_noovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 33);

    // Cancel together with start in IDLE: not accepted
    @(negedge clk_i);
    start_i = 1'b1; cancel_i = 1'b1; op_i = OP_DIVU; op1_i = 32'd50; op2_i = 32'd5; reg_waddr_i = 5'd20;
    #1;
    chk("idle_cancel_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    chk("idle_cancel_not_busy", {31'd0, stall_req_o}, 32'd0);
    chk("idle_cancel_waddr", {27'd0, reg_waddr_o}, 32'd16);

    // Cancel during DONE suppresses the strobe
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; op1_i = 32'd5; op2_i = 32'd0; reg_waddr_i = 5'd21;
    @(posedge clk_i); #1;
    start_i = 1'b0; cancel_i = 1'b1;
    #1;
    chk("done_cancel_valid", {31'd0, valid_o}, 32'd0);
    chk("done_cancel_we", {31'd0, reg_we_o}, 32'd0);
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    chk("done_cancel_after", {31'd0, valid_o}, 32'd0);

    // Cancel at BUSY iteration 10
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd22;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    cancel_i = 1'b1;
    #1;
    chk("busy_cancel_stall_held", {31'd0, stall_req_o}, 32'd1);
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    chk("busy_cancel_stall_drop", {31'd0, stall_req_o}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) vcnt++;
      @(posedge clk_i); #1;
    end
    chk("busy_cancel_no_valid", vcnt, 32'd0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd23, 32'd3, 33);

    // Reset at BUSY iteration 20
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd24;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mid_rst_result", result_o, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_we", {31'd0, reg_we_o}, 32'd0);
    chk("mid_rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) vcnt++;
      @(posedge clk_i); #1;
    end
    chk("mid_rst_no_valid", vcnt, 32'd0);
    run_op("div_by0_after_rst", OP_DIV, 32'd77, 32'd0, 5'd25, 32'hFFFF_FFFF, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
